// File: rtl/mips_avalon_master_if.sv
// Bundles the core request/response handshake and the Avalon-MM bus of the
// MIPS bus interface unit.
//   master modport : view of the bus interface unit (accepts core requests,
//                    drives the Avalon strobes)
//   slave modport  : view of the environment (core + Avalon slave)
// Signals:
//   req_valid/req_write/req_addr/req_wdata/req_byteenable : core request
//   req_ready                                             : request accepted
//   resp_valid/resp_rdata/resp_err                        : core response
//   address/read/write/writedata/byteenable               : Avalon command
//   waitrequest/readdata                                  : Avalon slave reply
interface mips_avalon_master_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byteenable;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_byteenable,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_byteenable,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_avalon_master.sv
// Avalon-MM bus interface unit for the MIPS core. Turns single-word core
// load/store requests into Avalon read/write transactions, one at a time,
// holding every bus output stable while waitrequest is high.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : mips_avalon_master_if.master (core request/response + Avalon bus)
// Parameters:
//   TIMEOUT_CYCLES    : consecutive waitrequest cycles before abort, 0 = never
//   RESET_VECTOR_ADDR : value on address out of reset
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a core request; misaligned requests answered here
// S_READ  | read strobe high, waiting for waitrequest low
// S_WRITE | write strobe high, waiting for waitrequest low
// S_RESP  | resp_valid cycle after a bus transaction, not ready
module mips_avalon_master #(
  parameter int unsigned TIMEOUT_CYCLES    = 0,
  parameter logic [31:0] RESET_VECTOR_ADDR = 32'hBFC00000
) (
  input logic                  clk,
  input logic                  rst_n,
  mips_avalon_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_address;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_writedata;
  logic [3:0]  r_byteenable;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_wait_cnt;

  logic        w_req_ready;
  logic [31:0] w_cnt_next;
  logic        w_timeout;

  assign w_req_ready = (r_state == S_IDLE) && rst_n;

  // Saturating so a stall longer than 2^32 cycles cannot wrap back to zero.
  assign w_cnt_next = (r_wait_cnt == 32'hFFFF_FFFF) ? r_wait_cnt : r_wait_cnt + 32'd1;
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_address    <= RESET_VECTOR_ADDR;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= 32'd0;
      r_byteenable <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_wait_cnt   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          if (w_req_ready && bus.req_valid) begin
            if (bus.req_addr[1:0] == 2'b00) begin
              r_address   <= bus.req_addr;
              r_writedata <= bus.req_wdata;
              if (bus.req_write) begin
                r_byteenable <= bus.req_byteenable;
                r_write      <= 1'b1;
                r_state      <= S_WRITE;
              end else begin
                r_byteenable <= 4'b1111;
                r_read       <= 1'b1;
                r_state      <= S_READ;
              end
            end else begin
              // Misaligned: answer directly without touching the bus.
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end
          end
        end

        S_READ, S_WRITE: begin
          if (!bus.waitrequest) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            if (r_state == S_READ) begin
              r_resp_rdata <= bus.readdata;
            end
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_state      <= S_RESP;
          end else begin
            r_wait_cnt <= w_cnt_next;
            if (w_timeout) begin
              r_read       <= 1'b0;
              r_write      <= 1'b0;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_state      <= S_RESP;
            end
          end
        end

        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_wait_cnt   <= 32'd0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.address    = r_address;
  assign bus.read       = r_read;
  assign bus.write      = r_write;
  assign bus.writedata  = r_writedata;
  assign bus.byteenable = r_byteenable;

endmodule

// File: doc/mips_avalon_master.md
Name: mips_avalon_master

Overview:
Avalon memory-mapped master (bus interface unit). It converts single-word load/store requests from the MIPS core into Avalon read/write transactions, and it pairs with the team's Avalon slave RAM model. It holds every bus signal stable while `waitrequest` is asserted and returns read data and status to the core through a simple valid/ready request and response interface. One transaction is in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 0, maximum number of consecutive cycles with `waitrequest` high before the transaction is aborted. 0 disables the timeout.
- RESET_VECTOR_ADDR, 32'hBFC00000, value driven on `address` out of reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  core request present.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; must be word-aligned.
- req_wdata  input  32  store data.
- req_byteenable  input  4  store byte lanes; ignored for loads.
- req_ready  output  1  block can accept a request this cycle.
- resp_valid  output  1  one-cycle pulse: the transaction has finished.
- resp_rdata  output  32  load data; valid while `resp_valid` is high.
- resp_err  output  1  qualifies `resp_valid`: misaligned access or timeout.
- address  output  32  Avalon address.
- read  output  1  Avalon read strobe.
- write  output  1  Avalon write strobe.
- writedata  output  32  Avalon write data.
- byteenable  output  4  Avalon byte enables.
- waitrequest  input  1  Avalon stall from the slave.
- readdata  input  32  Avalon read data.

Behaviour:
- Reset is synchronous. A rising edge with `rst_n` = 0 forces:
  - state IDLE;
  - `read` = 0, `write` = 0;
  - `address` = RESET_VECTOR_ADDR, `writedata` = 0, `byteenable` = 0;
  - `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0;
  - wait counter = 0.
- Reset asserted mid-transaction aborts it immediately. `read`/`write` drop at that edge and no response is generated.
- `req_ready` = 1 only in state IDLE with `rst_n` = 1 (combinational from state).
- States:
  - IDLE:
    - On `req_valid` & `req_ready` with `req_addr[1:0]` = 0: register `req_addr` into `address`, `req_wdata` into `writedata`, and byteenable (4'b1111 for loads, `req_byteenable` for stores). Assert `write` or `read` from the next cycle. Go to WRITE or READ.
    - On `req_valid` & `req_ready` with `req_addr[1:0]` != 0: no bus activity. Next cycle `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0. Stay in IDLE.
  - READ / WRITE:
    - Strobe held high. `address`, `writedata` and `byteenable` are not modified.
    - At a rising edge with `waitrequest` = 0: the transaction completes and the strobe deasserts that edge. For reads, `readdata` is captured into `resp_rdata`. In the same edge set `resp_valid` = 1, `resp_err` = 0, then go to RESP.
    - At a rising edge with `waitrequest` = 1: increment the wait counter. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: deassert the strobe, set `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0, and go to RESP.
  - RESP:
    - Clear `resp_valid` and the wait counter; return to IDLE.
    - `req_ready` = 0 in RESP, so the minimum spacing between strobe deassertion and the next strobe assertion is one idle cycle.
- Latency: request accepted at edge N → strobe high from N+1. Completion at the first edge E ≥ N+1 where `waitrequest` = 0. `resp_valid` is high for exactly the cycle after E.
- Invariants, asserted in the bench:
  - `read` and `write` are never both 1.
  - The strobe never deasserts before completion, except on timeout or reset.
  - `address[1:0]` = 0 whenever a strobe is high.
  - Bus outputs are constant while a strobe is high.
- `resp_rdata` holds its value until the next read completion or error.
- `req_*` inputs are ignored outside IDLE.
- Wait counter width: 32 bits; saturates, no wrap.

Test Plan:
1. Read, slave READ_DELAY=2, data[0x0]=0xDEADBEEF:
   - Stimulus: load from 0x00000000.
   - Required: `read` high for exactly 2 cycles; `address` stays 0x0; `resp_valid` pulses once with `resp_rdata` = 0xDEADBEEF, `resp_err` = 0.
2. Write, WRITE_DELAY=3:
   - Stimulus: store 0x11223344 with byteenable 4'b0101 to 0x8, where the word was 0xAABBCCDD.
   - Required: `write` held 3 cycles with `writedata`/`byteenable` constant; a follow-up read of 0x8 returns 0xAA22CC44.
3. Misaligned access:
   - Stimulus: load at 0xBFC00002.
   - Required: `read`/`write` stay 0 throughout; `resp_valid` and `resp_err` = 1 the next cycle; `req_ready` back to 1 after that.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=4 with `waitrequest` tied 1.
   - Required: `read` high 4 cycles then 0; `resp_err` = 1; `resp_rdata` = 0.
5. Reset mid-transaction:
   - Stimulus: drive `rst_n` = 0 on the 2nd wait cycle.
   - Required: strobes 0 at the next edge; `address` = 0xBFC00000; no `resp_valid`; the next request after reset completes normally.
6. Back-to-back:
   - Stimulus: `req_valid` held 1 for a load at 0xBFC00000 followed by a store to 0x4.
   - Required: exactly one idle cycle between `read` falling and `write` rising; never both strobes high.
